// File: rtl/fetch_stall_ctrl_if.sv
// Fetch/decode boundary bundle: hazard requests and branch redirect in,
// PC, IF/ID register, bubble, error flag and perf counters out.
interface fetch_stall_ctrl_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
);
    logic                   IF_ID_stall;
    logic                   Branch_taken;
    logic [PC_WIDTH-1:0]    Branch_target;
    logic [INSTR_WIDTH-1:0] IF_Instr;
    logic [PC_WIDTH-1:0]    PC;
    logic [INSTR_WIDTH-1:0] ID_Instr;
    logic [PC_WIDTH-1:0]    ID_PC_plus4;
    logic                   ID_Valid;
    logic                   ID_EX_bubble;
    logic                   Stall_err;
    logic [CNT_WIDTH-1:0]   Stall_count;
    logic [CNT_WIDTH-1:0]   Flush_count;

    modport master (
        output IF_ID_stall, Branch_taken, Branch_target, IF_Instr,
        input  PC, ID_Instr, ID_PC_plus4, ID_Valid, ID_EX_bubble,
        input  Stall_err, Stall_count, Flush_count
    );

    modport slave (
        input  IF_ID_stall, Branch_taken, Branch_target, IF_Instr,
        output PC, ID_Instr, ID_PC_plus4, ID_Valid, ID_EX_bubble,
        output Stall_err, Stall_count, Flush_count
    );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// PC and IF/ID register owner: load-use stall, branch flush, stall timeout.
// Define FETCH_STALL_CNT_EN to build the stall/flush perf counters.
module fetch_stall_ctrl #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  MAX_STALL   = 1,
    parameter int                  CNT_WIDTH   = 16
) (
    input logic               Clk,
    input logic               Rst_n,
    fetch_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_RUN = CNT_WIDTH'(MAX_STALL);

    state_t               state;
    logic [CNT_WIDTH-1:0] stall_run;
    logic                 stall_eff;
    logic [PC_WIDTH-1:0]  pc_plus4;

    // A bubble in IF/ID has no consumer to protect, so its stall is dropped.
    assign stall_eff = bus.IF_ID_stall & bus.ID_Valid & ~bus.Branch_taken;
    assign bus.ID_EX_bubble = stall_eff;
    assign pc_plus4 = bus.PC + PC_WIDTH'(4);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state           <= RUN;
            stall_run       <= '0;
            bus.PC          <= RESET_PC;
            bus.ID_Instr    <= '0;
            bus.ID_PC_plus4 <= '0;
            bus.ID_Valid    <= 1'b0;
            bus.Stall_err   <= 1'b0;
        end else begin
            unique case (1'b1)
                bus.Branch_taken: begin
                    bus.PC       <= bus.Branch_target;
                    bus.ID_Instr <= '0;
                    bus.ID_Valid <= 1'b0;
                    stall_run    <= '0;
                    state        <= FLUSH;
                end
                stall_eff: begin
                    if (state == STALL) begin
                        if (stall_run >= MAX_RUN) begin
                            bus.Stall_err <= 1'b1;
                        end
                        if (stall_run != '1) begin
                            stall_run <= stall_run + 1'b1;
                        end
                    end else begin
                        stall_run <= CNT_WIDTH'(1);
                    end
                    state <= STALL;
                end
                default: begin
                    bus.PC          <= pc_plus4;
                    bus.ID_Instr    <= bus.IF_Instr;
                    bus.ID_PC_plus4 <= pc_plus4;
                    bus.ID_Valid    <= 1'b1;
                    stall_run       <= '0;
                    state           <= RUN;
                end
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            bus.Stall_count <= '0;
            bus.Flush_count <= '0;
        end else begin
            if (stall_eff && bus.Stall_count != '1) begin
                bus.Stall_count <= bus.Stall_count + 1'b1;
            end
            if (bus.Branch_taken && bus.Flush_count != '1) begin
                bus.Flush_count <= bus.Flush_count + 1'b1;
            end
        end
    end
`else
    assign bus.Stall_count = '0;
    assign bus.Flush_count = '0;
`endif
endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Bench for fetch_stall_ctrl: directed vectors, literal checks and a
// per-cycle comparison against a behavioural fetch model.
module tb_fetch_stall_ctrl;
    localparam int MAXS = 1;
`ifdef FETCH_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    fetch_stall_ctrl_if #(.PC_WIDTH(32), .INSTR_WIDTH(32), .CNT_WIDTH(16)) bus ();

    fetch_stall_ctrl #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0),
        .MAX_STALL(MAXS), .CNT_WIDTH(16)
    ) dut (
        .Clk(clk),
        .Rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.IF_Instr = mem(bus.PC);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int n);
        return CNT_EN ? 32'(n) : 32'h0;
    endfunction

    // Behavioural model: what fetch must look like, from the rules alone.
    bit          m_ok = 1'b0;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_err;
    int          m_consec, m_stalls, m_flushes;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok = 1'b1;
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_err = 1'b0;
            m_consec = 0; m_stalls = 0; m_flushes = 0;
        end else if (m_ok) begin
            if (bus.Branch_taken) begin
                m_pc = bus.Branch_target;
                m_instr = 32'h0;
                m_valid = 1'b0;
                m_consec = 0;
                if (m_flushes < 65535) m_flushes++;
            end else if (bus.IF_ID_stall && m_valid) begin
                m_consec++;
                if (m_consec > MAXS) m_err = 1'b1;
                if (m_stalls < 65535) m_stalls++;
            end else begin
                m_instr = mem(m_pc);
                m_pc = m_pc + 32'd4;
                m_pc4 = m_pc;
                m_valid = 1'b1;
                m_consec = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_pc", bus.PC, m_pc);
            chk("model_instr", bus.ID_Instr, m_instr);
            chk("model_pc4", bus.ID_PC_plus4, m_pc4);
            chk("model_valid", 32'(bus.ID_Valid), 32'(m_valid));
            chk("model_err", 32'(bus.Stall_err), 32'(m_err));
            chk("model_bubble", 32'(bus.ID_EX_bubble),
                32'(bus.IF_ID_stall & m_valid & ~bus.Branch_taken));
            chk("model_scnt", 32'(bus.Stall_count), cnt(m_stalls));
            chk("model_fcnt", 32'(bus.Flush_count), cnt(m_flushes));
        end
    end

    task automatic drive(input logic s, input logic b, input logic [31:0] t);
        bus.IF_ID_stall = s;
        bus.Branch_taken = b;
        bus.Branch_target = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pat_s = 8'b0110_1101;
    logic [7:0] pat_b = 8'b1000_0100;

    initial begin
        drive(1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_pc", bus.PC, 32'h0);
        chk("rst_valid", 32'(bus.ID_Valid), 32'h0);
        chk("rst_instr", bus.ID_Instr, 32'h0);
        chk("rst_err", 32'(bus.Stall_err), 32'h0);

        rst_n = 1'b1;
        tick();
        chk("rel_pc", bus.PC, 32'h4);
        chk("rel_instr", bus.ID_Instr, mem(32'h0));
        chk("rel_valid", 32'(bus.ID_Valid), 32'h1);

        tick(); tick(); tick();
        chk("pre_stall_pc", bus.PC, 32'h10);
        drive(1'b1, 1'b0, 32'h0);
        chk("lu_bubble", 32'(bus.ID_EX_bubble), 32'h1);
        tick();
        chk("lu_pc_hold", bus.PC, 32'h10);
        chk("lu_instr_hold", bus.ID_Instr, mem(32'hC));
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk("lu_pc_adv", bus.PC, 32'h14);
        chk("lu_scnt", 32'(bus.Stall_count), cnt(1));

        tick(); tick(); tick();
        chk("pre_br_pc", bus.PC, 32'h20);
        drive(1'b0, 1'b1, 32'h40);
        tick();
        chk("br_pc", bus.PC, 32'h40);
        chk("br_valid", 32'(bus.ID_Valid), 32'h0);
        chk("br_instr", bus.ID_Instr, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk("br_tgt_instr", bus.ID_Instr, mem(32'h40));
        chk("br_pc4", bus.ID_PC_plus4, 32'h44);
        chk("br_fcnt", 32'(bus.Flush_count), cnt(1));

        drive(1'b1, 1'b1, 32'h80);
        chk("col_bubble", 32'(bus.ID_EX_bubble), 32'h0);
        tick();
        chk("col_pc", bus.PC, 32'h80);
        chk("col_scnt", 32'(bus.Stall_count), cnt(1));
        drive(1'b0, 1'b0, 32'h0);
        tick();

        drive(1'b1, 1'b0, 32'h0);
        tick();
        chk("to_err1", 32'(bus.Stall_err), 32'h0);
        tick();
        chk("to_err2", 32'(bus.Stall_err), 32'h1);
        tick();
        chk("to_pc_hold", bus.PC, 32'h84);
        chk("to_scnt", 32'(bus.Stall_count), cnt(4));
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk("to_pc_adv", bus.PC, 32'h88);
        chk("to_err_sticky", 32'(bus.Stall_err), 32'h1);
        drive(1'b1, 1'b0, 32'h0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_err", 32'(bus.Stall_err), 32'h0);
        chk("midrst_pc", bus.PC, 32'h0);
        chk("midrst_scnt", 32'(bus.Stall_count), 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;

        drive(1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        chk("wr_pc", bus.PC, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 32'h0);
        chk("ign_bubble", 32'(bus.ID_EX_bubble), 32'h0);
        tick();
        chk("wr_pc0", bus.PC, 32'h0);
        chk("wr_pc4", bus.ID_PC_plus4, 32'h0);
        chk("wr_valid", 32'(bus.ID_Valid), 32'h1);

        drive(1'b0, 1'b1, 32'h100);
        tick();
        drive(1'b0, 1'b1, 32'h200);
        tick();
        chk("b2b_pc", bus.PC, 32'h200);
        chk("b2b_valid", 32'(bus.ID_Valid), 32'h0);

        for (int i = 0; i < 24; i++) begin
            drive(pat_s[i % 8], pat_b[(i * 3) % 8], 32'h300 + 32'(i * 16));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
